// File: rtl/ballot_unit.sv
// Voter-facing ballot front end: synchronises and debounces candidate buttons and
// emits exactly one one-hot vote strobe per armed session.
module ballot_unit #(
   parameter int N_CAND          = 5,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic [N_CAND-1:0] btn,
   output logic [N_CAND-1:0] vote,
   output logic              ready,
   output logic              err_multi,
   output logic              timeout,
   output logic [15:0]       votes_cast
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]     TIMER_ONE  = TW'(1);
   localparam logic [DW-1:0]     DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0]     DCNT_ONE   = DW'(1);
   localparam logic [N_CAND-1:0] CAND_ZERO  = {N_CAND{1'b0}};
   localparam logic [N_CAND-1:0] CAND_ONE   = N_CAND'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      DEBOUNCE = 3'd2,
      CAST     = 3'd3,
      RELEASE  = 3'd4
   } state_t;

   state_t            state_r;
   logic [N_CAND-1:0] btn_meta_r;
   logic [N_CAND-1:0] btn_sync_r;
   logic [N_CAND-1:0] cap_r;
   logic [DW-1:0]     dcnt_r;
   logic [TW-1:0]     timer_r;

   function automatic logic is_onehot(input logic [N_CAND-1:0] v);
      return (v != CAND_ZERO) && ((v & (v - CAND_ONE)) == CAND_ZERO);
   endfunction

   function automatic logic is_multi(input logic [N_CAND-1:0] v);
      return (v != CAND_ZERO) && !is_onehot(v);
   endfunction

   // Two-flop synchroniser for the asynchronous buttons
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta_r <= CAND_ZERO;
         btn_sync_r <= CAND_ZERO;
      end else begin
         btn_meta_r <= btn;
         btn_sync_r <= btn_meta_r;
      end
   end

   // Session FSM with timer, debounce counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cap_r      <= CAND_ZERO;
         dcnt_r     <= {DW{1'b0}};
         timer_r    <= {TW{1'b0}};
         vote       <= CAND_ZERO;
         ready      <= 1'b0;
         err_multi  <= 1'b0;
         timeout    <= 1'b0;
         votes_cast <= 16'h0000;
      end else begin
         vote      <= CAND_ZERO;
         ready     <= 1'b0;
         err_multi <= 1'b0;
         timeout   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (arm) begin
                  state_r <= ARMED;
                  timer_r <= {TW{1'b0}};
                  dcnt_r  <= {DW{1'b0}};
                  ready   <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            ARMED, DEBOUNCE: begin
               // Expiry takes priority over any capture or debounce completion
               if (timer_r == TIMER_LAST) begin
                  state_r <= IDLE;
                  timeout <= 1'b1;
                  dcnt_r  <= {DW{1'b0}};
               end else begin
                  timer_r <= timer_r + TIMER_ONE;
                  ready   <= 1'b1;
                  if (state_r == ARMED) begin
                     if (is_onehot(btn_sync_r)) begin
                        cap_r   <= btn_sync_r;
                        dcnt_r  <= {DW{1'b0}};
                        state_r <= DEBOUNCE;
                     end else if (is_multi(btn_sync_r)) begin
                        err_multi <= 1'b1;
                     end else begin
                        state_r <= ARMED;
                     end
                  end else if (btn_sync_r == cap_r) begin
                     if (dcnt_r == DCNT_LAST) begin
                        state_r <= CAST;
                        vote    <= cap_r;
                        ready   <= 1'b0;
                        if (votes_cast != 16'hFFFF) begin
                           votes_cast <= votes_cast + 16'h0001;
                        end else begin
                           votes_cast <= votes_cast;
                        end
                     end else begin
                        dcnt_r <= dcnt_r + DCNT_ONE;
                     end
                  end else begin
                     state_r <= ARMED;
                     dcnt_r  <= {DW{1'b0}};
                  end
               end
            end
            CAST: begin
               state_r <= RELEASE;
            end
            RELEASE: begin
               if (btn_sync_r == CAND_ZERO) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= RELEASE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ballot_unit.sv
// Bench for ballot_unit: vector table, directed corner sequences and randomized
// stimulus, all checked every cycle against a session-level reference model.
module tb_ballot_unit;

   localparam int NC = 5;
   localparam int DC = 4;
   localparam int TO = 1000;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm;
   logic [NC-1:0] btn;
   logic [NC-1:0] vote;
   logic          ready;
   logic          err_multi;
   logic          timeout;
   logic [15:0]   votes_cast;

   ballot_unit #(.N_CAND(NC), .DEBOUNCE_CYCLES(DC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .arm(arm), .btn(btn), .vote(vote), .ready(ready),
      .err_multi(err_multi), .timeout(timeout), .votes_cast(votes_cast)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: session mode 0 idle, 1 armed, 3 casting, 2 waiting release
   logic [NC-1:0] m_s1, m_s2, m_held, e_vote;
   logic          e_ready, e_err, e_to;
   int            m_mode, m_age, m_run, e_cast;

   // observation counters
   int            v_seen, err_seen, to_seen;
   logic [NC-1:0] v_last;

   typedef struct {
      logic [NC-1:0] press;
      int            hold;
      logic [NC-1:0] exp_vote;
      logic          exp_err;
   } vec_t;
   vec_t tbl[7];

   function automatic int pop(input logic [NC-1:0] v);
      int c = 0;
      for (int i = 0; i < NC; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic model_edge();
      logic [NC-1:0] bs;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_held = '0; m_mode = 0; m_age = 0; m_run = 0;
         e_vote = '0; e_ready = 1'b0; e_err = 1'b0; e_to = 1'b0; e_cast = 0;
      end else begin
         bs = m_s2; m_s2 = m_s1; m_s1 = btn;
         e_vote = '0; e_err = 1'b0; e_to = 1'b0;
         case (m_mode)
            0: if (arm) begin m_mode = 1; m_age = 0; m_run = 0; end
            1: begin
               m_age++;
               if (m_age == TO) begin
                  m_mode = 0; e_to = 1'b1;
               end else if (pop(bs) == 1 && (m_run == 0 || bs == m_held)) begin
                  if (m_run == 0) m_held = bs;
                  m_run++;
                  if (m_run == DC + 1) begin
                     e_vote = m_held;
                     if (e_cast < 65535) e_cast++;
                     m_mode = 3;
                  end
               end else if (m_run > 0) begin
                  m_run = 0;
               end else if (pop(bs) > 1) begin
                  e_err = 1'b1;
               end
            end
            3: m_mode = 2;
            2: if (bs == '0) m_mode = 0;
            default: m_mode = 0;
         endcase
         e_ready = (m_mode == 1);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      n_cmp++;
      if (vote !== e_vote || ready !== e_ready || err_multi !== e_err ||
          timeout !== e_to || votes_cast !== 16'(e_cast)) begin
         n_bad++;
         $display("FAIL cycle @%0t: got vote=%b ready=%b err=%b to=%b cast=%0d, want vote=%b ready=%b err=%b to=%b cast=%0d",
                  $time, vote, ready, err_multi, timeout, votes_cast,
                  e_vote, e_ready, e_err, e_to, e_cast);
      end
      if (vote != '0) begin v_seen++; v_last = vote; end
      if (err_multi) err_seen++;
      if (timeout) to_seen++;
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic clr_obs();
      v_seen = 0; err_seen = 0; to_seen = 0; v_last = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; step(); rst = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1; step(); arm = 1'b0;
   endtask

   initial begin
      int lat, to_step, r;
      logic [NC-1:0] one;
      one = 5'b00001;
      rst = 1'b1; arm = 1'b0; btn = '0;
      clr_obs();
      step(); step();
      chk("reset_vote", int'(vote), 0);
      chk("reset_ready", int'(ready), 0);
      chk("reset_cast", int'(votes_cast), 0);
      rst = 1'b0;

      tbl[0] = '{5'b00100, 10, 5'b00100, 1'b0};
      tbl[1] = '{5'b00001,  8, 5'b00001, 1'b0};
      tbl[2] = '{5'b10000,  5, 5'b10000, 1'b0};
      tbl[3] = '{5'b00010,  4, 5'b00000, 1'b0};
      tbl[4] = '{5'b01010, 10, 5'b00000, 1'b1};
      tbl[5] = '{5'b11111,  3, 5'b00000, 1'b1};
      tbl[6] = '{5'b00000, 10, 5'b00000, 1'b0};
      for (int i = 0; i < 7; i++) begin
         do_reset(); do_arm(); clr_obs();
         btn = tbl[i].press;
         repeat (tbl[i].hold) step();
         btn = '0;
         repeat (8) step();
         chk("tbl_votes", v_seen, (tbl[i].exp_vote != '0) ? 1 : 0);
         chk("tbl_value", int'(v_last), int'(tbl[i].exp_vote));
         chk("tbl_err", (err_seen > 0) ? 1 : 0, int'(tbl[i].exp_err));
      end

      // clean press: latency, single pulse, counter, ready
      do_reset(); do_arm(); clr_obs();
      btn = 5'b00100; lat = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (vote != '0 && lat == 0) lat = k;
      end
      chk("t1_latency", lat, 7);
      chk("t1_pulses", v_seen, 1);
      chk("t1_value", int'(v_last), 4);
      chk("t1_cast", int'(votes_cast), 1);
      chk("t1_ready", int'(ready), 0);

      // multi-press then valid press in the same session
      btn = '0; repeat (4) step();
      do_arm(); clr_obs();
      btn = 5'b01010; repeat (20) step();
      btn = '0; repeat (5) step();
      chk("t2_err_pulses", err_seen, 20);
      chk("t2_no_vote", v_seen, 0);
      btn = 5'b00001; repeat (10) step();
      btn = '0; repeat (4) step();
      chk("t2_votes", v_seen, 1);
      chk("t2_value", int'(v_last), 1);

      // bouncing button then stable
      do_arm(); clr_obs();
      btn = 5'b10000; step();
      btn = '0; repeat (2) step();
      btn = 5'b10000; step();
      btn = '0; repeat (2) step();
      chk("t3_bounce_novote", v_seen, 0);
      btn = 5'b10000; repeat (12) step();
      btn = '0; repeat (4) step();
      chk("t3_votes", v_seen, 1);
      chk("t3_value", int'(v_last), 16);

      // timeout; an arm mid-session does not extend it
      do_arm(); clr_obs();
      to_step = 0;
      for (int k = 1; k <= TO + 5; k++) begin
         arm = (k == 500);
         step();
         if (timeout && to_step == 0) to_step = k;
      end
      arm = 1'b0;
      chk("t4_timeout_step", to_step, TO);
      chk("t4_timeout_pulses", to_seen, 1);
      chk("t4_ready", int'(ready), 0);
      chk("t4_cast", int'(votes_cast), 3);
      btn = 5'b00100; repeat (10) step();
      btn = '0; repeat (4) step();
      chk("t4_no_arm_novote", v_seen, 0);

      // held button after CAST, arm ignored until released and re-armed
      do_reset(); clr_obs();
      for (int s = 0; s < 5; s++) begin
         do_arm();
         btn = one << s; repeat (10) step();
         do_arm(); repeat (10) step();
         btn = '0; repeat (4) step();
      end
      chk("t5_votes", v_seen, 5);
      chk("t5_cast", int'(votes_cast), 5);

      // reset in the cycle before CAST
      do_reset(); do_arm(); clr_obs();
      btn = 5'b00100; repeat (6) step();
      rst = 1'b1; step();
      chk("t6_vote", int'(vote), 0);
      chk("t6_ready", int'(ready), 0);
      chk("t6_err", int'(err_multi), 0);
      chk("t6_timeout", int'(timeout), 0);
      chk("t6_cast", int'(votes_cast), 0);
      rst = 1'b0; repeat (10) step();
      btn = '0; repeat (3) step();
      chk("t6_no_vote", v_seen, 0);

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) btn = '0;
         else if (r == 1) btn = NC'($urandom);
         else if (r <= 3) btn = one << $urandom_range(0, NC - 1);
         arm = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; arm = 1'b0; btn = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
